// File: rtl/airi5c_hasti_wait_bridge_pkg.sv
// Shared HASTI bus constants, bridge state encoding and LFSR helper for the
// wait-state injecting bridge and its LFSR.
package airi5c_hasti_wait_bridge_pkg;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_TRANS_WIDTH = 2;

  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'b00;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'b01;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'b10;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'b11;

  localparam logic HASTI_RESP_OKAY = 1'b0;

  localparam int WAIT_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } state_e;

  // Fibonacci feedback for taps 16,14,13,11.
  function automatic logic lfsr16_feedback(input logic [15:0] s);
    return s[15] ^ s[13] ^ s[12] ^ s[10];
  endfunction

endpackage

// File: rtl/airi5c_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), reusable by other
// stress blocks; the seed must be nonzero.
module airi5c_lfsr16
  import airi5c_hasti_wait_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Shift left, feedback into bit 0.
  always_comb begin
    state_d = {state_q[14:0], lfsr16_feedback(state_q)};
  end

  // State register, reloaded with the seed on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/airi5c_hasti_wait_bridge.sv
// AHB-Lite bridge that re-issues each upstream transfer to a zero-wait memory
// after a fixed or LFSR-chosen number of wait states.
module airi5c_hasti_wait_bridge
  import airi5c_hasti_wait_bridge_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 32'd0,
  parameter bit          RANDOM      = 1'b0,
  parameter int unsigned MAX_WAIT    = 32'd7,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic [HASTI_ADDR_WIDTH-1:0]  s_haddr,
  input  logic                         s_hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  s_hsize,
  input  logic [HASTI_TRANS_WIDTH-1:0] s_htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   s_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   s_hrdata,
  output logic                         s_hready,
  output logic                         s_hresp,
  output logic [HASTI_ADDR_WIDTH-1:0]  m_haddr,
  output logic                         m_hwrite,
  output logic [HASTI_SIZE_WIDTH-1:0]  m_hsize,
  output logic [HASTI_TRANS_WIDTH-1:0] m_htrans,
  output logic [HASTI_BUS_WIDTH-1:0]   m_hwdata,
  input  logic [HASTI_BUS_WIDTH-1:0]   m_hrdata,
  input  logic                         m_hready,
  output logic [31:0]                  stall_count
);

  localparam logic [WAIT_CNT_WIDTH-1:0] FIXED_WAIT = WAIT_CNT_WIDTH'(WAIT_CYCLES);
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_ONE   = WAIT_CNT_WIDTH'(32'd1);
  localparam logic [4:0]                RAND_MOD   = 5'(MAX_WAIT + 32'd1);

  state_e                        state_q, state_d;
  logic [HASTI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                          write_q, write_d;
  logic [HASTI_SIZE_WIDTH-1:0]   size_q, size_d;
  logic [HASTI_BUS_WIDTH-1:0]    wdata_q, wdata_d;
  logic                          cap_q, cap_d;
  logic [WAIT_CNT_WIDTH-1:0]     wait_q, wait_d;
  logic [31:0]                   stall_q, stall_d;

  logic [15:0]                   lfsr_s;
  logic                          lfsr_unused_s;
  logic [4:0]                    rand_mod_s;
  logic [WAIT_CNT_WIDTH-1:0]     wait_load_s;
  logic                          accept_s;
  logic                          s_hready_s;
  logic [HASTI_BUS_WIDTH-1:0]    s_hrdata_s;
  logic [HASTI_TRANS_WIDTH-1:0]  m_htrans_s;

  airi5c_lfsr16 u_lfsr (
    .clk   (hclk),
    .rst_n (hresetn),
    .seed  (LFSR_SEED),
    .state (lfsr_s)
  );

  assign lfsr_unused_s = ^lfsr_s[15:4];

  // Next-state, upstream handshake and downstream request generation.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    size_d     = size_q;
    wait_d     = wait_q;
    cap_d      = 1'b0;
    s_hready_s = 1'b1;
    s_hrdata_s = '0;
    m_htrans_s = HASTI_TRANS_IDLE;

    rand_mod_s  = {1'b0, lfsr_s[3:0]} % RAND_MOD;
    wait_load_s = RANDOM ? WAIT_CNT_WIDTH'(rand_mod_s) : FIXED_WAIT;

    // Write data belongs to the cycle right after the address phase.
    if (cap_q) begin
      wdata_d = s_hwdata;
    end else begin
      wdata_d = wdata_q;
    end

    case (state_q)
      ST_IDLE: begin
        s_hready_s = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_WAIT: begin
        s_hready_s = 1'b0;
        wait_d     = wait_q - WAIT_ONE;
        if (wait_q <= WAIT_ONE) begin
          state_d = ST_ADDR;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ADDR: begin
        s_hready_s = 1'b0;
        m_htrans_s = HASTI_TRANS_NONSEQ;
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        s_hready_s = m_hready;
        s_hrdata_s = m_hrdata;
        if (m_hready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A completing data phase may accept the next transfer in the same cycle.
    accept_s = s_hready_s &&
               ((s_htrans == HASTI_TRANS_NONSEQ) || (s_htrans == HASTI_TRANS_SEQ));
    if (accept_s) begin
      addr_d  = s_haddr;
      write_d = s_hwrite;
      size_d  = s_hsize;
      wait_d  = wait_load_s;
      cap_d   = 1'b1;
      if (wait_load_s != '0) begin
        state_d = ST_WAIT;
      end else begin
        state_d = ST_ADDR;
      end
    end else begin
      cap_d = 1'b0;
    end

    if (!s_hready_s && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      cap_q   <= 1'b0;
      wait_q  <= '0;
      stall_q <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign s_hready    = s_hready_s;
  assign s_hrdata    = s_hrdata_s;
  assign s_hresp     = HASTI_RESP_OKAY;
  assign m_htrans    = m_htrans_s;
  assign m_haddr     = addr_q;
  assign m_hwrite    = write_q;
  assign m_hsize     = size_q;
  assign m_hwdata    = wdata_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_airi5c_hasti_wait_bridge.sv
// Directed bench for the wait bridge: three bridge instances (3 fixed waits,
// 0 fixed waits, random waits up to 5), each in front of a small SRAM model.
module tb_airi5c_hasti_wait_bridge;
  import airi5c_hasti_wait_bridge_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic [31:0] rdata;
    int          stalls;
  } xfer_t;

  logic hclk    = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  logic [31:0] s_haddr_a  [3];
  logic        s_hwrite_a [3];
  logic [2:0]  s_hsize_a  [3];
  logic [1:0]  s_htrans_a [3];
  logic [31:0] s_hwdata_a [3];
  logic [31:0] s_hrdata_a [3];
  logic        s_hready_a [3];
  logic        s_hresp_a  [3];
  logic [31:0] stall_a    [3];
  int          ns_a       [3];
  int          hold_cfg   [3];

  xfer_t       xf [1024];
  int          xf_n;
  logic [31:0] sb [256];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Little-endian byte-lane merge of a write into a memory word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] off,
                                        input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] r;
    logic        hit;
    r = old;
    for (int b = 0; b < 4; b++) begin
      case (size)
        3'd0:    hit = (b == int'(off));
        3'd1:    hit = ((b / 2) == int'(off[1]));
        default: hit = 1'b1;
      endcase
      if (hit) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] m_haddr, m_hwdata, m_hrdata;
    logic        m_hwrite, m_hready;
    logic [2:0]  m_hsize;
    logic [1:0]  m_htrans;
    logic [31:0] mem [256];
    logic        ph_v = 1'b0;
    logic [31:0] ph_addr = 32'h0;
    logic        ph_write = 1'b0;
    logic [2:0]  ph_size = 3'd0;
    int          hold_r = 0;
    int          ns_cnt = 0;

    airi5c_hasti_wait_bridge #(
      .WAIT_CYCLES ((g == 0) ? 3 : 0),
      .RANDOM      ((g == 2) ? 1'b1 : 1'b0),
      .MAX_WAIT    (5),
      .LFSR_SEED   (16'hACE1)
    ) u_dut (
      .hclk        (hclk),
      .hresetn     (hresetn),
      .s_haddr     (s_haddr_a[g]),
      .s_hwrite    (s_hwrite_a[g]),
      .s_hsize     (s_hsize_a[g]),
      .s_htrans    (s_htrans_a[g]),
      .s_hwdata    (s_hwdata_a[g]),
      .s_hrdata    (s_hrdata_a[g]),
      .s_hready    (s_hready_a[g]),
      .s_hresp     (s_hresp_a[g]),
      .m_haddr     (m_haddr),
      .m_hwrite    (m_hwrite),
      .m_hsize     (m_hsize),
      .m_htrans    (m_htrans),
      .m_hwdata    (m_hwdata),
      .m_hrdata    (m_hrdata),
      .m_hready    (m_hready),
      .stall_count (stall_a[g])
    );

    assign m_hready = (hold_r == 0);
    assign m_hrdata = ph_v ? mem[ph_addr[9:2]] : 32'h0;
    assign ns_a[g]  = ns_cnt;

    initial begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end

    // SRAM model: address phase on NONSEQ, write committed at end of data phase.
    always @(posedge hclk) begin
      if (!hresetn) begin
        ph_v   <= 1'b0;
        hold_r <= 0;
      end else begin
        if (m_hready) begin
          if (ph_v && ph_write)
            mem[ph_addr[9:2]] <= merge(mem[ph_addr[9:2]], ph_addr[1:0], ph_size, m_hwdata);
          ph_v     <= (m_htrans == HASTI_TRANS_NONSEQ);
          ph_addr  <= m_haddr;
          ph_write <= m_hwrite;
          ph_size  <= m_hsize;
          hold_r   <= (m_htrans == HASTI_TRANS_NONSEQ) ? hold_cfg[g] : 0;
        end else begin
          hold_r <= hold_r - 1;
        end
        if (m_htrans == HASTI_TRANS_NONSEQ) ns_cnt <= ns_cnt + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add_xfer(input logic [31:0] a, input logic w, input logic [2:0] s,
                          input logic [31:0] wd, input logic [31:0] e);
    xf[xf_n].addr   = a;
    xf[xf_n].wr     = w;
    xf[xf_n].size   = s;
    xf[xf_n].wdata  = wd;
    xf[xf_n].exp    = e;
    xf[xf_n].rdata  = 32'h0;
    xf[xf_n].stalls = 0;
    xf_n++;
  endtask

  // Pipelined master: drives xf[0..xf_n-1] back-to-back into instance d.
  // Must be entered on a falling clock edge.
  task automatic run_seq(input int d, input string tag);
    int ai;
    int dp;
    int cyc;
    ai  = 0;
    dp  = -1;
    cyc = 0;
    while (ai < xf_n || dp >= 0) begin
      if (ai < xf_n) begin
        s_htrans_a[d] = HASTI_TRANS_NONSEQ;
        s_haddr_a[d]  = xf[ai].addr;
        s_hwrite_a[d] = xf[ai].wr;
        s_hsize_a[d]  = xf[ai].size;
      end else begin
        s_htrans_a[d] = HASTI_TRANS_IDLE;
      end
      s_hwdata_a[d] = (dp >= 0) ? xf[dp].wdata : 32'h0;
      #1;
      if (s_hready_a[d]) begin
        if (dp >= 0) xf[dp].rdata = s_hrdata_a[d];
        if (ai < xf_n) begin
          dp = ai;
          ai++;
        end else begin
          dp = -1;
        end
      end else if (dp >= 0) begin
        xf[dp].stalls++;
      end
      @(negedge hclk);
      cyc++;
      if (cyc > 20 * xf_n + 20) begin
        check_eq({tag, "_timeout"}, 32'd1, 32'd0);
        break;
      end
    end
    s_htrans_a[d] = HASTI_TRANS_IDLE;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          ns0;
    logic [31:0] st0;
    int          lows;
    int          mism;
    int          bad;
    logic [5:0]  seen;
    int          word;
    int          off;
    logic [2:0]  sz;
    logic        wr;
    logic [31:0] wd;

    for (int i = 0; i < 3; i++) begin
      s_htrans_a[i] = HASTI_TRANS_IDLE;
      s_haddr_a[i]  = 32'h0;
      s_hwrite_a[i] = 1'b0;
      s_hsize_a[i]  = 3'd2;
      s_hwdata_a[i] = 32'h0;
      hold_cfg[i]   = 0;
    end
    for (int i = 0; i < 256; i++) sb[i] = 32'h0;
    xf_n = 0;

    repeat (3) @(negedge hclk);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("rst_hready%0d", d), 32'(s_hready_a[d]), 32'd1);
      check_eq($sformatf("rst_hrdata%0d", d), s_hrdata_a[d], 32'h0);
      check_eq($sformatf("rst_stall%0d", d), stall_a[d], 32'd0);
    end
    check_eq("rst_htrans", 32'(g_dut[0].m_htrans), 32'(HASTI_TRANS_IDLE));
    check_eq("rst_hresp", 32'(s_hresp_a[0]), 32'd0);
    hresetn = 1'b1;
    @(negedge hclk);

    // Three fixed waits: write then read back.
    xf_n = 0;
    add_xfer(32'h100, 1'b1, 3'd2, 32'hCAFEBABE, 32'h0);
    add_xfer(32'h100, 1'b0, 3'd2, 32'h0, 32'hCAFEBABE);
    ns0 = ns_a[0];
    run_seq(0, "t1");
    check_eq("t1_wr_stalls", 32'(xf[0].stalls), 32'd4);
    check_eq("t1_rd_stalls", 32'(xf[1].stalls), 32'd4);
    check_eq("t1_rdata", xf[1].rdata, 32'hCAFEBABE);
    check_eq("t1_stall_count", stall_a[0], 32'd8);
    check_eq("t1_nonseq", 32'(ns_a[0] - ns0), 32'd2);

    // Memory holds hready low for two extra data-phase cycles.
    hold_cfg[0] = 2;
    xf_n = 0;
    add_xfer(32'h100, 1'b0, 3'd2, 32'h0, 32'hCAFEBABE);
    run_seq(0, "hold");
    hold_cfg[0] = 0;
    check_eq("hold_stalls", 32'(xf[0].stalls), 32'd6);
    check_eq("hold_rdata", xf[0].rdata, 32'hCAFEBABE);
    check_eq("hold_stall_count", stall_a[0], 32'd14);

    // Zero waits: preload then back-to-back reads.
    xf_n = 0;
    add_xfer(32'h0, 1'b1, 3'd2, 32'd1, 32'h0);
    add_xfer(32'h4, 1'b1, 3'd2, 32'd2, 32'h0);
    add_xfer(32'h8, 1'b1, 3'd2, 32'd3, 32'h0);
    run_seq(1, "t2pre");
    xf_n = 0;
    add_xfer(32'h0, 1'b0, 3'd2, 32'h0, 32'd1);
    add_xfer(32'h4, 1'b0, 3'd2, 32'h0, 32'd2);
    add_xfer(32'h8, 1'b0, 3'd2, 32'h0, 32'd3);
    ns0 = ns_a[1];
    run_seq(1, "t2");
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t2_rdata%0d", i), xf[i].rdata, xf[i].exp);
      check_eq($sformatf("t2_stalls%0d", i), 32'(xf[i].stalls), 32'd1);
    end
    check_eq("t2_nonseq", 32'(ns_a[1] - ns0), 32'd3);

    // Byte write into the top lane of a word.
    xf_n = 0;
    add_xfer(32'h200, 1'b1, 3'd2, 32'h11223344, 32'h0);
    add_xfer(32'h203, 1'b1, 3'd0, 32'h5A000000, 32'h0);
    add_xfer(32'h200, 1'b0, 3'd2, 32'h0, 32'h5A223344);
    run_seq(1, "t3");
    check_eq("t3_rdata", xf[2].rdata, 32'h5A223344);

    // BUSY and IDLE transfers never stall and never reach the memory.
    ns0  = ns_a[1];
    st0  = stall_a[1];
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      s_htrans_a[1] = (i % 2 == 0) ? HASTI_TRANS_BUSY : HASTI_TRANS_IDLE;
      s_haddr_a[1]  = 32'h40 + 32'(4 * i);
      #1;
      if (!s_hready_a[1]) lows++;
      @(negedge hclk);
    end
    s_htrans_a[1] = HASTI_TRANS_IDLE;
    check_eq("busy_hready_low", 32'(lows), 32'd0);
    check_eq("busy_nonseq", 32'(ns_a[1] - ns0), 32'd0);
    check_eq("busy_stall_count", stall_a[1], st0);

    // Random waits: 1000 mixed transfers against the scoreboard.
    xf_n = 0;
    for (int i = 0; i < 1000; i++) begin
      word = int'($urandom_range(0, 255));
      sz   = 3'($urandom_range(0, 2));
      off  = (sz == 3'd0) ? int'($urandom_range(0, 3)) :
             (sz == 3'd1) ? 2 * int'($urandom_range(0, 1)) : 0;
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom();
      if (wr) begin
        sb[word] = merge(sb[word], 2'(off), sz, wd);
        add_xfer({22'h0, 8'(word), 2'(off)}, 1'b1, sz, wd, 32'h0);
      end else begin
        add_xfer({22'h0, 8'(word), 2'(off)}, 1'b0, sz, 32'h0, sb[word]);
      end
    end
    ns0 = ns_a[2];
    run_seq(2, "rnd");
    mism = 0;
    bad  = 0;
    seen = 6'h00;
    for (int i = 0; i < xf_n; i++) begin
      if (!xf[i].wr && (xf[i].rdata !== xf[i].exp)) mism++;
      if (xf[i].stalls < 1 || xf[i].stalls > 6) bad++;
      else seen[xf[i].stalls - 1] = 1'b1;
    end
    check_eq("rnd_data_mismatches", 32'(mism), 32'd0);
    check_eq("rnd_stall_out_of_range", 32'(bad), 32'd0);
    check_eq("rnd_stall_lengths_seen", 32'(seen), 32'h3F);
    check_eq("rnd_nonseq", 32'(ns_a[2] - ns0), 32'd1000);

    // Reset during the wait phase of a write drops the write.
    xf_n = 0;
    add_xfer(32'h300, 1'b1, 3'd2, 32'h0BADF00D, 32'h0);
    run_seq(0, "t5pre");
    s_htrans_a[0] = HASTI_TRANS_NONSEQ;
    s_haddr_a[0]  = 32'h300;
    s_hwrite_a[0] = 1'b1;
    s_hsize_a[0]  = 3'd2;
    @(negedge hclk);
    s_htrans_a[0] = HASTI_TRANS_IDLE;
    s_hwdata_a[0] = 32'hDEADBEEF;
    #1;
    check_eq("t5_wait_hready", 32'(s_hready_a[0]), 32'd0);
    ns0 = ns_a[0];
    hresetn = 1'b0;
    #1;
    check_eq("t5_rst_hready", 32'(s_hready_a[0]), 32'd1);
    check_eq("t5_rst_htrans", 32'(g_dut[0].m_htrans), 32'(HASTI_TRANS_IDLE));
    @(negedge hclk);
    hresetn = 1'b1;
    repeat (4) @(negedge hclk);
    check_eq("t5_nonseq", 32'(ns_a[0] - ns0), 32'd0);
    check_eq("t5_stall_cleared", stall_a[0], 32'd0);
    xf_n = 0;
    add_xfer(32'h300, 1'b0, 3'd2, 32'h0, 32'h0BADF00D);
    run_seq(0, "t5rd");
    check_eq("t5_mem_unchanged", xf[0].rdata, 32'h0BADF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
